// File: rtl/spi_xfer_arbiter_if.sv
// Requester handshake, tagged receive return path and SPI pins of spi_xfer_arbiter.
// master = requesters + SPI slave side, slave = the arbiter itself.
interface spi_xfer_arbiter_if;
   logic       req_a, req_b;
   logic [7:0] tx_a, tx_b;
   logic       last_a, last_b;
   logic       gnt_a, gnt_b;
   logic [7:0] rx_data;
   logic       rx_valid, rx_owner, busy;
   logic       spi_cs, spi_sck, spi_mosi_out, spi_miso_in;

   modport master (
      output req_a, req_b, tx_a, tx_b, last_a, last_b, spi_miso_in,
      input  gnt_a, gnt_b, rx_data, rx_valid, rx_owner, busy,
             spi_cs, spi_sck, spi_mosi_out
   );

   modport slave (
      input  req_a, req_b, tx_a, tx_b, last_a, last_b, spi_miso_in,
      output gnt_a, gnt_b, rx_data, rx_valid, rx_owner, busy,
             spi_cs, spi_sck, spi_mosi_out
   );
endinterface

// File: rtl/spi_xfer_arbiter.sv
// Two-requester SPI frame scheduler: round-robin per frame, MSB-first shifting,
// received bytes returned tagged with the requester that owns the frame.
module spi_xfer_arbiter #(
   parameter int CS_SETUP = 2,
   parameter int CS_HOLD  = 1
) (
   input  logic              spi_clk,
   input  logic              n_reset,
   spi_xfer_arbiter_if.slave bus
);
   localparam int MAXSH = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
   localparam int MAXC  = (MAXSH > 16) ? MAXSH : 16;
   localparam int CW    = $clog2(MAXC + 1);
   localparam logic [CW-1:0] SETUP_END = CW'(CS_SETUP - 1);
   localparam logic [CW-1:0] HOLD_END  = CW'(CS_HOLD - 1);
   localparam logic [CW-1:0] SHIFT_END = CW'(15);

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, NEXT, HOLD} state_t;

   state_t        r_state, w_state_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt;
   logic [7:0]    r_sh, r_rx_data;
   logic          r_last, r_owner, r_ptr;
   logic          r_gnt_a, r_gnt_b, r_rx_valid, r_rx_owner;
   logic          w_gnt_a, w_gnt_b, w_sample, w_done, w_pick_b, w_cs;

   // Pointer side wins when it requests, otherwise the other side is served.
   assign w_pick_b = r_ptr ? bus.req_b : ~bus.req_a;

   always_ff @(posedge spi_clk or negedge n_reset) begin
      if (!n_reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_gnt_a     = 1'b0;
      w_gnt_b     = 1'b0;
      w_sample    = 1'b0;
      w_done      = 1'b0;
      unique case (r_state)
         IDLE: if (bus.req_a || bus.req_b) begin
            w_gnt_a     = ~w_pick_b;
            w_gnt_b     = w_pick_b;
            w_state_nxt = SETUP;
            w_cnt_nxt   = '0;
         end
         SETUP: if (r_cnt == SETUP_END) begin
            w_state_nxt = SHIFT;
            w_cnt_nxt   = '0;
         end else w_cnt_nxt = r_cnt + 1'b1;
         // cnt[4:1] is the bit index, cnt[0] the sck phase
         SHIFT: begin
            w_cnt_nxt = r_cnt + 1'b1;
            w_sample  = r_cnt[0];
            if (r_cnt == SHIFT_END) begin
               w_done      = 1'b1;
               w_cnt_nxt   = '0;
               w_state_nxt = r_last ? HOLD : NEXT;
            end
         end
         NEXT: if (r_owner ? bus.req_b : bus.req_a) begin
            w_gnt_a     = ~r_owner;
            w_gnt_b     = r_owner;
            w_state_nxt = SHIFT;
            w_cnt_nxt   = '0;
         end
         HOLD: if (r_cnt == HOLD_END) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
         end else w_cnt_nxt = r_cnt + 1'b1;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge spi_clk or negedge n_reset) begin
      if (!n_reset) begin
         r_sh       <= '0;
         r_last     <= 1'b0;
         r_owner    <= 1'b0;
         r_ptr      <= 1'b0;
         r_gnt_a    <= 1'b0;
         r_gnt_b    <= 1'b0;
         r_rx_valid <= 1'b0;
         r_rx_data  <= '0;
         r_rx_owner <= 1'b0;
      end else begin
         r_gnt_a    <= w_gnt_a;
         r_gnt_b    <= w_gnt_b;
         r_rx_valid <= w_done;
         // One register shifts MOSI out and MISO in; after 8 samples it holds the rx byte.
         if (w_gnt_a || w_gnt_b) begin
            r_sh    <= w_gnt_b ? bus.tx_b : bus.tx_a;
            r_last  <= w_gnt_b ? bus.last_b : bus.last_a;
            r_owner <= w_gnt_b;
         end else if (w_sample) begin
            r_sh <= {r_sh[6:0], bus.spi_miso_in};
         end
         if (w_done) begin
            r_rx_data  <= {r_sh[6:0], bus.spi_miso_in};
            r_rx_owner <= r_owner;
         end
         if (r_state == HOLD && w_state_nxt == IDLE) r_ptr <= ~r_owner;
      end
   end

   assign w_cs             = (r_state == IDLE) || (r_state == HOLD);
   assign bus.spi_cs       = w_cs;
   assign bus.spi_sck      = (r_state == SHIFT) && r_cnt[0];
   assign bus.spi_mosi_out = ~w_cs & r_sh[7];
   assign bus.gnt_a        = r_gnt_a;
   assign bus.gnt_b        = r_gnt_b;
   assign bus.rx_valid     = r_rx_valid;
   assign bus.rx_data      = r_rx_data;
   assign bus.rx_owner     = r_rx_owner;
   assign bus.busy         = (r_state != IDLE);
endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Randomized bench for spi_xfer_arbiter: queue-driven requesters, an SPI slave
// model and a frame-level reference of arbitration, framing and byte return.
module tb_spi_xfer_arbiter;
   localparam int CS_SETUP = 2;
   localparam int CS_HOLD  = 1;

   typedef struct packed { logic [7:0] d; logic l; } item_t;
   typedef struct packed { logic o; logic [7:0] d; } exp_t;
   typedef struct packed { logic [7:0] mosi; logic [7:0] miso; } sl_t;

   logic clk = 1'b0;
   logic n_reset = 1'b1;
   always #5 clk = ~clk;

   spi_xfer_arbiter_if bus();
   spi_xfer_arbiter #(.CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD)) dut (
      .spi_clk(clk), .n_reset(n_reset), .bus(bus.slave)
   );

   int         n_vec = 0, n_bad = 0;
   item_t      qa[$], qb[$];
   exp_t       exp_q[$];
   sl_t        sl_q[$];
   logic [7:0] miso_q[$];
   bit         rx_log[$], fr_log[$];
   int         gap_log[$];
   bit         stall_a = 0, skip_len = 0, pop_a = 0, pop_b = 0;
   bit         ptr_m = 0, cur_own = 0, prev_cs = 1, prev_ra = 0, prev_rb = 0;
   int         cs_low = 0, cs_high = 1000, nbytes = 0, sl_k = 7;
   logic [7:0] sl_m = 0, sl_acc = 0, last_rx = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic item_t mk(input logic [7:0] d, input logic l);
      item_t it;
      it.d = d;
      it.l = l;
      return it;
   endfunction

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_cs"},    bus.spi_cs, 1);
      chk({tag, "_sck"},   bus.spi_sck, 0);
      chk({tag, "_mosi"},  bus.spi_mosi_out, 0);
      chk({tag, "_gnt"},   {bus.gnt_a, bus.gnt_b}, 0);
      chk({tag, "_rxv"},   bus.rx_valid, 0);
      chk({tag, "_rxd"},   bus.rx_data, 0);
      chk({tag, "_rxo"},   bus.rx_owner, 0);
      chk({tag, "_busy"},  bus.busy, 0);
   endtask

   task automatic wait_idle(input int max);
      int n = 0;
      while ((bus.busy || qa.size() != 0 || qb.size() != 0) && n < max) begin
         @(negedge clk);
         n++;
      end
      chk("wait_idle_bound", n < max, 1);
   endtask

   task automatic wait_gnt(input bit b, input int max);
      int n = 0;
      while (!(b ? bus.gnt_b : bus.gnt_a) && n < max) begin
         @(negedge clk);
         n++;
      end
      chk("wait_gnt_bound", n < max, 1);
   endtask

   task automatic clr_logs();
      rx_log.delete();
      fr_log.delete();
      gap_log.delete();
   endtask

   // Requesters, SPI slave and reference checks, all on the falling edge.
   initial begin
      bus.req_a = 0; bus.req_b = 0; bus.tx_a = 0; bus.tx_b = 0;
      bus.last_a = 0; bus.last_b = 0; bus.spi_miso_in = 0;
      forever begin
         exp_t e;
         sl_t  s;
         bit   who, want;
         @(negedge clk);
         if (!n_reset) begin
            qa.delete(); qb.delete(); exp_q.delete(); sl_q.delete();
            pop_a = 0; pop_b = 0; ptr_m = 0; prev_cs = 1; prev_ra = 0; prev_rb = 0;
            cs_low = 0; cs_high = 1000; nbytes = 0; sl_k = 7;
         end else begin
            if (pop_a) begin if (qa.size() != 0) void'(qa.pop_front()); pop_a = 0; end
            if (pop_b) begin if (qb.size() != 0) void'(qb.pop_front()); pop_b = 0; end

            if (bus.gnt_a || bus.gnt_b) begin
               who = bus.gnt_b;
               chk("gnt_excl", bus.gnt_a & bus.gnt_b, 0);
               if (prev_cs) begin
                  want = ptr_m ? prev_rb : !prev_ra;
                  chk("arb_pick", who, want);
                  chk("cs_gap", cs_high >= CS_HOLD + 1, 1);
                  cur_own = who; nbytes = 0; cs_low = 0;
                  fr_log.push_back(who);
                  gap_log.push_back(cs_high);
               end else begin
                  chk("gnt_owner", who, cur_own);
               end
               nbytes++;
               chk("gnt_had_req", who ? (qb.size() != 0) : (qa.size() != 0), 1);
               e.o = who;
               if (who && qb.size() != 0) begin e.d = qb[0].d; exp_q.push_back(e); end
               if (!who && qa.size() != 0) begin e.d = qa[0].d; exp_q.push_back(e); end
               if (who) pop_b = 1; else pop_a = 1;
            end

            if (!bus.spi_cs) cs_low++;
            else begin
               if (!prev_cs) begin
                  if (!skip_len) chk("cs_low_len", cs_low, CS_SETUP + 17 * nbytes - 1);
                  ptr_m = ~cur_own;
                  cs_high = 0;
               end
               cs_high++;
            end

            if (bus.spi_cs) sl_k = 7;
            else if (bus.spi_sck) begin
               if (sl_k == 7) sl_m = (miso_q.size() != 0) ? miso_q.pop_front() : 8'($urandom);
               sl_acc = {sl_acc[6:0], bus.spi_mosi_out};
               bus.spi_miso_in = sl_m[sl_k];
               if (sl_k == 0) begin
                  s.mosi = sl_acc; s.miso = sl_m;
                  sl_q.push_back(s);
                  sl_k = 7;
               end else sl_k--;
            end

            if (bus.rx_valid) begin
               chk("rx_expected", (exp_q.size() != 0) && (sl_q.size() != 0), 1);
               if (exp_q.size() != 0 && sl_q.size() != 0) begin
                  e = exp_q.pop_front();
                  s = sl_q.pop_front();
                  chk("rx_owner", bus.rx_owner, e.o);
                  chk("mosi_byte", s.mosi, e.d);
                  chk("rx_data", bus.rx_data, s.miso);
               end
               rx_log.push_back(bus.rx_owner);
               last_rx = bus.rx_data;
            end

            bus.req_a  = (qa.size() != 0) && !stall_a;
            bus.tx_a   = (qa.size() != 0) ? qa[0].d : 8'h00;
            bus.last_a = (qa.size() != 0) ? qa[0].l : 1'b0;
            bus.req_b  = (qb.size() != 0);
            bus.tx_b   = (qb.size() != 0) ? qb[0].d : 8'h00;
            bus.last_b = (qb.size() != 0) ? qb[0].l : 1'b0;
            prev_ra = bus.req_a;
            prev_rb = bus.req_b;
            prev_cs = bus.spi_cs;
         end
      end
   end

   initial begin
      int n;
      #2 n_reset = 1'b0;
      #1 chk_reset_outputs("rst");
      repeat (2) @(negedge clk);
      n_reset = 1'b1;
      @(negedge clk);

      // single byte A5 out, 3C in
      clr_logs();
      miso_q.push_back(8'h3C);
      qa.push_back(mk(8'hA5, 1'b1));
      wait_idle(200);
      chk("single_rx", last_rx, 8'h3C);
      chk("single_cnt", rx_log.size(), 1);

      // asynchronous reset in the middle of a byte
      qa.push_back(mk(8'h96, 1'b1));
      n = 0;
      while (!bus.spi_sck && n < 100) begin @(negedge clk); n++; end
      chk("reach_shift", n < 100, 1);
      #2 n_reset = 1'b0;
      #1 chk_reset_outputs("midrst");
      repeat (2) @(negedge clk);
      n_reset = 1'b1;
      @(negedge clk);

      // simultaneous requests: pointer is back at A
      clr_logs();
      qa.push_back(mk(8'h11, 1'b1));
      qb.push_back(mk(8'h22, 1'b1));
      wait_idle(300);
      chk("simul_cnt", rx_log.size(), 2);
      if (rx_log.size() == 2) begin
         chk("simul_o0", rx_log[0], 0);
         chk("simul_o1", rx_log[1], 1);
      end
      if (gap_log.size() == 2) chk("simul_gap", gap_log[1], CS_HOLD + 1);

      // two-byte frame from B while A waits
      clr_logs();
      qb.push_back(mk(8'hF0, 1'b0));
      qb.push_back(mk(8'h0F, 1'b1));
      wait_gnt(1'b1, 50);
      qa.push_back(mk(8'($urandom), 1'b1));
      wait_idle(400);
      chk("multi_cnt", rx_log.size(), 3);
      if (rx_log.size() == 3) begin
         chk("multi_o0", rx_log[0], 1);
         chk("multi_o1", rx_log[1], 1);
         chk("multi_o2", rx_log[2], 0);
      end
      if (gap_log.size() == 2) chk("multi_gap", gap_log[1], CS_HOLD + 1);

      // continuation stall in NEXT with B requesting
      clr_logs();
      skip_len = 1;
      qa.push_back(mk(8'h5A, 1'b0));
      wait_gnt(1'b0, 50);
      stall_a = 1;
      qa.push_back(mk(8'hC3, 1'b1));
      qb.push_back(mk(8'h77, 1'b1));
      n = 0;
      while (!bus.rx_valid && n < 60) begin @(negedge clk); n++; end
      chk("stall_rx_bound", n < 60, 1);
      repeat (20) begin
         @(negedge clk);
         chk("stall_cs", bus.spi_cs, 0);
         chk("stall_sck", bus.spi_sck, 0);
         chk("stall_gnt", {bus.gnt_a, bus.gnt_b}, 0);
      end
      stall_a = 0;
      wait_idle(400);
      skip_len = 0;
      chk("stall_cnt", rx_log.size(), 3);
      if (rx_log.size() == 3) begin
         chk("stall_o0", rx_log[0], 0);
         chk("stall_o1", rx_log[1], 0);
         chk("stall_o2", rx_log[2], 1);
      end

      // fairness: both sides saturated
      clr_logs();
      repeat (3) begin
         qa.push_back(mk(8'($urandom), 1'b1));
         qb.push_back(mk(8'($urandom), 1'b1));
      end
      wait_idle(800);
      chk("fair_frames", fr_log.size(), 6);
      for (int i = 0; i < fr_log.size(); i++) chk("fair_order", fr_log[i], i % 2);

      // random traffic
      for (int k = 0; k < 40; k++) begin
         int nb;
         bit r;
         r  = 1'($urandom_range(0, 1));
         nb = $urandom_range(1, 3);
         for (int j = 0; j < nb; j++) begin
            if (r) qb.push_back(mk(8'($urandom), j == nb - 1));
            else   qa.push_back(mk(8'($urandom), j == nb - 1));
         end
         repeat ($urandom_range(0, 40)) @(negedge clk);
      end
      wait_idle(8000);
      repeat (3) @(negedge clk);
      chk("all_returned", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
